eth_tlpsend: RTL and testbench
==============================

Name: eth_tlpsend

Overview:
- Transmit-side counterpart of the TLP tap: pops 74-bit TLP words from the tap-format FIFO and replays them as a 64-bit AXI4-Stream toward the 10G Ethernet TX path.
- Contains a 2-entry output buffer that absorbs the FIFO's 1-cycle read latency, so full throughput holds under backpressure.
- Truncates overlong frames.
- Provides packet and truncation statistics.

Parameters:
- C_DATA_WIDTH, 64, AXIS data width; fixed at 64.
- MAX_BEATS, 256, maximum beats per frame before forced truncation (range 2..65535).

Ports:
- clk156  input  1  core clock; all logic rising-edge.
- sys_rst  input  1  synchronous, active-high reset.
- rd_en  output  1  FIFO read strobe.
- dout  input  74  FIFO word {tkeep[7:0], tdata[63:0], tlast, tuser}; valid one cycle after rd_en (standard, non-FWFT).
- empty  input  1  FIFO empty.
- m_axis_tdata  output  64  stream data.
- m_axis_tkeep  output  8  byte enables.
- m_axis_tlast  output  1  end of frame.
- m_axis_tuser  output  1  frame error / abort.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- stat_pkts  output  32  frames emitted with tlast; wraps.
- stat_trunc  output  16  frames truncated; saturates at 0xFFFF.

Behaviour:
- Reset (sys_rst=1 at an edge) clears:
  - rd_en, m_axis_tvalid, tlast, tuser: 0.
  - tdata, tkeep: 0.
  - buffer occupancy and in-flight flag.
  - beat counter and both statistics: 0.
  - state: IDLE.
- Reset mid-frame:
  - Buffered words and any in-flight FIFO word are discarded.
  - No tlast is generated for the interrupted frame.
  - The FIFO and its writer share this reset.
- Unpacking: tkeep = dout[73:66], tdata = dout[65:2], tlast = dout[1], tuser = dout[0].
- Read issue (combinational):
  - rd_en = !empty && (occ + inflight − pop) < 2, where pop = m_axis_tvalid && m_axis_tready.
  - inflight is a register equal to the previous cycle's rd_en.
  - Never more than 2 words are held or pending.
- Latency:
  - With empty falling in cycle 0 and the buffer empty, rd_en is high in cycle 0.
  - dout is valid in cycle 1.
  - m_axis_tvalid is high in cycle 2.
  - Steady state: 1 beat/cycle while tready=1 and the FIFO is non-empty.
- AXIS rules:
  - Output held stable while tvalid && !tready.
  - Buffer order is FIFO.
  - Simultaneous push and pop are allowed at occ=1 or occ=2.
- Frame FSM, evaluated on each word arriving from the FIFO (inflight=1):
  - IDLE: word pushed and beat counter set to 1. If tlast=1, stay IDLE; otherwise go to FRAME.
  - FRAME: word pushed and beat counter incremented.
    - tlast=1: go to IDLE.
    - Counter reaches MAX_BEATS without tlast: the word is pushed with tlast=1 and tuser=1, stat_trunc increments, go to DROP.
  - DROP: word discarded (not pushed, does not count toward occupancy). Return to IDLE on a word with tlast=1.
- A word with tlast=1 at exactly beat MAX_BEATS is a normal frame, not a truncation.
- Incoming tuser=1 is forwarded unchanged and not interpreted.
- stat_pkts increments on each output handshake with tlast=1, truncated frames included.
- tkeep is not validated; it is passed through.

Decomposition:
- eth_tlp_pkg, shared with the tap:
  - TLP_FIFO_W=74 and field offset constants (KEEP_LSB=66, DATA_LSB=2, LAST_BIT=1, USER_BIT=0).
  - packed struct tlp_word_t {keep, data, last, user}.
  - enum tx_state_t {IDLE, FRAME, DROP}.
- One sub-module, axis_skid2:
  - 2-entry FIFO-ordered output buffer of tlp_word_t.
  - push/pop, exposes occ[1:0].
  - Holds all AXIS output registers.

Test Plan:
- Basic timing: FIFO holds one 3-beat frame (data 0x11.., 0x22.., 0x33..; tkeep FF, FF, 0F; tlast on beat 3), tready=1. Expect rd_en in cycles 0–2, tvalid in cycles 2–4 with identical data/keep, tlast only on 0x33.., stat_pkts=1.
- Backpressure: 8-beat frame with tready pattern 1,0,0,1,0,1,1,0… Expect no loss or duplication, outputs stable during stalls, rd_en low whenever occ+inflight−pop=2, beat order preserved.
- Truncation: MAX_BEATS=4, 6-beat frame followed by a 2-beat frame. Expect 4 beats with beat 4 tlast=1/tuser=1, beats 5–6 dropped, stat_trunc=1, second frame intact, stat_pkts=2.
- Exact limit and passthrough: MAX_BEATS=4 with a 4-beat frame whose last beat has tuser=1. Expect a normal frame with tuser=1 passed through and stat_trunc=0.
- Empty gaps: empty toggling every cycle mid-frame. Expect tvalid bubbles only, correct frame reassembly, no spurious rd_en while empty=1.
- Reset mid-frame: sys_rst asserted for one cycle after beat 2 of a 5-beat frame with 2 words buffered. Next cycle tvalid=0 and both statistics=0; FSM in IDLE; the following frame is forwarded correctly.

Source files
------------

// File: rtl/eth_tlpsend_pkg.sv
// eth_tlp_pkg: definitions shared between the TLP tap and the TLP sender.
//   TLP_FIFO_W   : width of one tap-format FIFO word
//   *_LSB / *_BIT: field offsets inside a FIFO word
//   tlp_word_t   : unpacked view {keep, data, last, user}; same bit layout as the FIFO word
//   tx_state_t   : sender frame state
//   tlp_unpack() : FIFO word -> tlp_word_t
package eth_tlp_pkg;

  localparam int TLP_FIFO_W = 74;
  localparam int KEEP_LSB   = 66;
  localparam int DATA_LSB   = 2;
  localparam int LAST_BIT   = 1;
  localparam int USER_BIT   = 0;

  typedef struct packed {
    logic [7:0]  keep;
    logic [63:0] data;
    logic        last;
    logic        user;
  } tlp_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } tx_state_t;

  function automatic tlp_word_t tlp_unpack(input logic [TLP_FIFO_W-1:0] w);
    tlp_word_t t;
    t.keep = w[KEEP_LSB +: 8];
    t.data = w[DATA_LSB +: 64];
    t.last = w[LAST_BIT];
    t.user = w[USER_BIT];
    return t;
  endfunction

endpackage

// File: rtl/eth_tlpsend_axis_skid2.sv
// axis_skid2: 2-entry, FIFO-ordered output buffer that drives the AXIS
// master registers directly.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i/push_word_i: write one word (caller guarantees room)
//   tready_i          : downstream ready
//   t*_o              : AXIS outputs, all taken from the head register
//   pop_o             : output handshake this cycle (tvalid && tready)
//   occ_o             : number of held words (0..2)
//
// Handshake: a beat transfers on a rising edge where tvalid_o && tready_i;
// while tvalid_o && !tready_i the head register is not written, so every
// output stays stable until accepted.
module axis_skid2
  import eth_tlp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  tlp_word_t   push_word_i,
  input  logic        tready_i,
  output logic [63:0] tdata_o,
  output logic [7:0]  tkeep_o,
  output logic        tlast_o,
  output logic        tuser_o,
  output logic        tvalid_o,
  output logic        pop_o,
  output logic [1:0]  occ_o
);

  logic [1:0] occ_q, occ_d;
  tlp_word_t  head_q, head_d;
  tlp_word_t  tail_q, tail_d;

  assign tvalid_o = (occ_q != 2'd0);
  assign pop_o    = tvalid_o && tready_i;
  assign occ_o    = occ_q;
  assign tdata_o  = head_q.data;
  assign tkeep_o  = head_q.keep;
  assign tlast_o  = head_q.last;
  assign tuser_o  = head_q.user;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // head_q is the oldest word; tail_q is only meaningful at occ=2.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({push_i, pop_o})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = push_word_i;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = push_word_i;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_word_i;
        end else begin
          head_d = tail_q;
          tail_d = push_word_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eth_tlpsend.sv
// eth_tlpsend: pops tap-format TLP words from a standard (non-FWFT) FIFO and
// replays them as a 64-bit AXI4-Stream, truncating frames longer than
// MAX_BEATS and counting emitted / truncated frames.
//   clk156, sys_rst : clock, synchronous active-high reset
//   rd_en/dout/empty: FIFO read side; dout valid the cycle after rd_en
//   m_axis_*        : AXIS master (tdata, tkeep, tlast, tuser, tvalid, tready)
//   stat_pkts       : frames emitted with tlast (wraps)
//   stat_trunc      : frames truncated (saturates)
//   dbg_state       : current frame state
// C_DATA_WIDTH must stay 64; the word format fixes the data field width.
module eth_tlpsend
  import eth_tlp_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int MAX_BEATS    = 256
) (
  input  logic                    clk156,
  input  logic                    sys_rst,
  output logic                    rd_en,
  input  logic [TLP_FIFO_W-1:0]   dout,
  input  logic                    empty,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [7:0]              m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             stat_pkts,
  output logic [15:0]             stat_trunc,
  output tx_state_t               dbg_state
);

  localparam logic [15:0] MAX_B = 16'(MAX_BEATS);

  tx_state_t  state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic        inflight_q;
  logic [31:0] pkts_q;
  logic [15:0] trunc_q;

  tlp_word_t   in_word;
  tlp_word_t   push_word;
  logic        push;
  logic        trunc_evt;
  logic        pop;
  logic [1:0]  occ;
  logic [2:0]  committed;
  logic [15:0] beat_inc;

  assign in_word  = tlp_unpack(dout);
  assign beat_inc = beat_q + 16'd1;

  // Words already held or on their way, minus the one leaving this cycle.
  // A word that will be dropped still counts while in flight, which keeps
  // the bound conservative.
  assign committed = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = !sys_rst && !empty && (committed < 3'd2);

  // State register
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      beat_q     <= 16'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      inflight_q <= rd_en;
    end
  end

  // Next-state logic: only advances when a FIFO word arrives.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (inflight_q) begin
      unique case (state_q)
        IDLE: begin
          beat_d  = 16'd1;
          state_d = in_word.last ? IDLE : FRAME;
        end
        FRAME: begin
          beat_d = beat_inc;
          if (in_word.last)            state_d = IDLE;
          else if (beat_inc == MAX_B)  state_d = DROP;
        end
        DROP: begin
          if (in_word.last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: what to push into the buffer for the arriving word.
  always_comb begin
    push      = 1'b0;
    push_word = in_word;
    trunc_evt = 1'b0;
    if (inflight_q) begin
      unique case (state_q)
        IDLE:  push = 1'b1;
        FRAME: begin
          push = 1'b1;
          // Limit reached without end of frame: close it as an aborted frame.
          if (!in_word.last && (beat_inc == MAX_B)) begin
            push_word.last = 1'b1;
            push_word.user = 1'b1;
            trunc_evt      = 1'b1;
          end
        end
        default: push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      pkts_q  <= 32'd0;
      trunc_q <= 16'd0;
    end else begin
      if (pop && m_axis_tlast) pkts_q <= pkts_q + 32'd1;
      if (trunc_evt && (trunc_q != 16'hFFFF)) trunc_q <= trunc_q + 16'd1;
    end
  end

  axis_skid2 u_skid (
    .clk_i       (clk156),
    .rst_i       (sys_rst),
    .push_i      (push),
    .push_word_i (push_word),
    .tready_i    (m_axis_tready),
    .tdata_o     (m_axis_tdata),
    .tkeep_o     (m_axis_tkeep),
    .tlast_o     (m_axis_tlast),
    .tuser_o     (m_axis_tuser),
    .tvalid_o    (m_axis_tvalid),
    .pop_o       (pop),
    .occ_o       (occ)
  );

  assign stat_pkts  = pkts_q;
  assign stat_trunc = trunc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_eth_tlpsend.sv
module tb_eth_tlpsend;
  import eth_tlp_pkg::*;

  localparam int MAXB = 4;

  // ---------------- clock / reset ----------------
  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  logic        sys_rst = 1'b1;
  logic        rd_en;
  logic [73:0] dout = '0;
  logic        empty = 1'b1;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tuser, m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] stat_pkts;
  logic [15:0] stat_trunc;
  tx_state_t   dbg_state;

  eth_tlpsend #(.C_DATA_WIDTH(64), .MAX_BEATS(MAXB)) dut (
    .clk156        (clk156),
    .sys_rst       (sys_rst),
    .rd_en         (rd_en),
    .dout          (dout),
    .empty         (empty),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .stat_pkts     (stat_pkts),
    .stat_trunc    (stat_trunc),
    .dbg_state     (dbg_state)
  );

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_mis = 0;

  logic [74:0] fifo_q[$];   // {dropped_by_reference, fifo word}
  logic [73:0] exp_q[$];    // expected output beats {keep,data,last,user}
  int exp_pkts = 0;
  int exp_trunc = 0;

  int   m_occ = 0;          // reference count of words held for output
  int   m_infl = 0;         // word read last cycle
  logic infl_drop = 1'b0;   // that word is discarded by the frame rules
  logic rd_seen = 1'b0, pop_seen = 1'b0, rst_seen = 1'b0;
  logic prev_stall = 1'b0;
  logic [73:0] prev_out = '0;
  int hs_cnt = 0;

  // stimulus controls
  int   rdy_mode = 0;        // 0: tready_n, 1: fixed pattern, 2: random
  logic tready_n = 1'b1;
  logic [7:0] rdy_pat = 8'b0110_1001;  // 1,0,0,1,0,1,1,0 from bit 0
  int   pat_idx = 0;
  int   gap_mode = 0;        // 0: none, 1: every other cycle, 2: random
  logic gap_ph = 1'b0;
  int   stop_after = 0;      // tready forced low once hs_cnt reaches this
  logic rst_req = 1'b1;

  wire [73:0] out_word = {m_axis_tkeep, m_axis_tdata, m_axis_tlast, m_axis_tuser};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: observe at negedge, then at posedge+1 advance the
  // FIFO/reference model and drive the next cycle's inputs.
  task automatic tick();
    logic pop_m;
    logic [74:0] e;
    logic gap;
    @(negedge clk156);
    if (sys_rst) begin
      rd_seen = 1'b0; pop_seen = 1'b0; rst_seen = 1'b1; prev_stall = 1'b0;
    end else begin
      rst_seen = 1'b0;
      pop_m = (m_occ != 0) && m_axis_tready;
      chk("tvalid", m_axis_tvalid, m_occ != 0);
      chk("rd_en", rd_en, !empty && ((m_occ + m_infl - (pop_m ? 1 : 0)) < 2));
      if (prev_stall) chk("stall_hold", out_word, prev_out);
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
        else chk("beat", out_word, exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = out_word;
      rd_seen    = rd_en;
      pop_seen   = pop_m;
    end
    @(posedge clk156);
    #1;
    if (rst_seen) begin
      m_occ = 0; m_infl = 0; infl_drop = 1'b0;
      fifo_q.delete();
      dout = '0;
    end else begin
      if (m_infl != 0 && !infl_drop) m_occ++;
      if (pop_seen) m_occ--;
      m_infl = rd_seen ? 1 : 0;
      if (rd_seen) begin
        if (fifo_q.size() == 0) chk("fifo_underflow", fifo_q.size(), 1);
        else begin
          e = fifo_q.pop_front();
          dout = e[73:0];
          infl_drop = e[74];
        end
      end
    end
    gap_ph = ~gap_ph;
    gap = (gap_mode == 1) ? gap_ph : (gap_mode == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
    empty = (fifo_q.size() == 0) || gap;
    if (rdy_mode == 1) begin
      m_axis_tready = rdy_pat[pat_idx % 8];
      pat_idx++;
    end else if (rdy_mode == 2) m_axis_tready = ($urandom_range(0, 3) != 0);
    else m_axis_tready = tready_n;
    if (stop_after > 0 && hs_cnt >= stop_after) m_axis_tready = 1'b0;
    sys_rst = rst_req;
    #1;
  endtask

  // Queue one frame into the FIFO and derive its expected output beats from
  // the frame rules: frames up to MAXB beats pass unchanged; longer frames
  // keep their first MAXB beats, the last of which is marked tlast+tuser.
  task automatic load_frame(input int len, input bit fixed, input bit user_last);
    tlp_word_t t, e;
    logic [7:0] b;
    exp_pkts++;
    if (len > MAXB) exp_trunc++;
    for (int i = 1; i <= len; i++) begin
      if (fixed) begin
        b = 8'(i * 17);
        t.data = {8{b}};
        t.keep = (i == len) ? 8'h0F : 8'hFF;
        t.user = user_last && (i == len);
      end else begin
        t.data = {$urandom, $urandom};
        t.keep = 8'($urandom_range(0, 255));
        t.user = ($urandom_range(0, 7) == 0);
      end
      t.last = (i == len);
      fifo_q.push_back({(i > MAXB), t});
      if (i <= MAXB) begin
        e = t;
        if (i == MAXB && len > MAXB) begin
          e.last = 1'b1;
          e.user = 1'b1;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && m_occ == 0 && m_infl == 0) && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_drain_in_time"}, n < 400, 1'b1);
    repeat (2) tick();
    chk({tag, "_stat_pkts"}, stat_pkts, exp_pkts);
    chk({tag, "_stat_trunc"}, stat_trunc, exp_trunc);
    chk({tag, "_state_idle"}, dbg_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset
    rst_req = 1'b1;
    repeat (3) tick();
    rst_req = 1'b0;
    tick();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 64'h0);
    chk("rst_tkeep", m_axis_tkeep, 8'h0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tuser", m_axis_tuser, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_pkts", stat_pkts, 32'd0);
    chk("rst_trunc", stat_trunc, 16'd0);
    chk("rst_state", dbg_state, IDLE);

    // Basic timing: 3-beat frame, tready=1; empty falls in cycle 0.
    load_frame(3, 1'b1, 1'b0);
    tick();  // cycle 0
    chk("bt_c0_rd", rd_en, 1'b1);  chk("bt_c0_tv", m_axis_tvalid, 1'b0);
    tick();  // cycle 1
    chk("bt_c1_rd", rd_en, 1'b1);  chk("bt_c1_tv", m_axis_tvalid, 1'b0);
    tick();  // cycle 2
    chk("bt_c2_rd", rd_en, 1'b1);  chk("bt_c2_tv", m_axis_tvalid, 1'b1);
    chk("bt_c2_data", m_axis_tdata, 64'h1111_1111_1111_1111);
    chk("bt_c2_last", m_axis_tlast, 1'b0);
    tick();  // cycle 3
    chk("bt_c3_rd", rd_en, 1'b0);  chk("bt_c3_tv", m_axis_tvalid, 1'b1);
    tick();  // cycle 4
    chk("bt_c4_rd", rd_en, 1'b0);  chk("bt_c4_tv", m_axis_tvalid, 1'b1);
    chk("bt_c4_data", m_axis_tdata, 64'h3333_3333_3333_3333);
    chk("bt_c4_keep", m_axis_tkeep, 8'h0F);
    chk("bt_c4_last", m_axis_tlast, 1'b1);
    tick();  // cycle 5
    chk("bt_c5_tv", m_axis_tvalid, 1'b0);
    drain("basic");
    chk("basic_pkts1", stat_pkts, 32'd1);

    // Exact limit with tuser passthrough on the last beat.
    load_frame(MAXB, 1'b1, 1'b1);
    drain("exact");
    chk("exact_no_trunc", stat_trunc, 16'd0);

    // Truncation: 6-beat frame then a 2-beat frame.
    load_frame(6, 1'b1, 1'b0);
    load_frame(2, 1'b1, 1'b0);
    drain("trunc");
    chk("trunc_one", stat_trunc, 16'd1);
    chk("trunc_pkts", stat_pkts, 32'd4);

    // Backpressure pattern, including a long frame.
    rdy_mode = 1; pat_idx = 0;
    load_frame(4, 1'b0, 1'b0);
    load_frame(3, 1'b0, 1'b0);
    load_frame(8, 1'b0, 1'b0);
    drain("bp");
    rdy_mode = 0;

    // Empty toggling every cycle mid-frame.
    gap_mode = 1;
    load_frame(4, 1'b0, 1'b0);
    load_frame(3, 1'b0, 1'b0);
    drain("gaps");
    gap_mode = 0;

    // Reset after beat 2 of a 5-beat frame with two words buffered.
    tready_n = 1'b1;
    stop_after = hs_cnt + 2;
    load_frame(5, 1'b1, 1'b0);
    for (int k = 0; k < 50 && hs_cnt < stop_after; k++) tick();
    chk("rst_mid_reached_beat2", hs_cnt >= stop_after, 1'b1);
    repeat (4) tick();
    chk("rst_mid_full_tv", m_axis_tvalid, 1'b1);
    chk("rst_mid_full_rd", rd_en, 1'b0);
    chk("rst_mid_fifo_nonempty", empty, 1'b0);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    chk("rst_mid_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_mid_pkts", stat_pkts, 32'd0);
    chk("rst_mid_trunc", stat_trunc, 16'd0);
    chk("rst_mid_state", dbg_state, IDLE);
    exp_q.delete();
    exp_pkts = 0;
    exp_trunc = 0;
    stop_after = 0;
    load_frame(3, 1'b0, 1'b0);
    drain("post_rst");
    chk("post_rst_pkts1", stat_pkts, 32'd1);

    // Random soak: random frame lengths, backpressure and FIFO gaps.
    rdy_mode = 2;
    gap_mode = 2;
    for (int f = 0; f < 40; f++) begin
      for (int w = 0; w < 100 && fifo_q.size() > 6; w++) tick();
      load_frame($urandom_range(1, 7), 1'b0, 1'b0);
      tick();
    end
    drain("random");
    rdy_mode = 0;
    gap_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
